// File: rtl/hci_core_mem_responder_if.sv
// HCI-Core request/response link. The initiator drives requests and r_ready;
// the target answers with gnt and the in-order response beat.
interface hci_core_intf #(
    parameter int unsigned DW = 32,
    parameter int unsigned UW = 1
);
    localparam int unsigned BW = DW / 8;

    logic          req;
    logic          gnt;
    logic [31:0]   add;
    logic          wen;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [UW-1:0] user;
    logic          r_ready;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic [UW-1:0] r_user;

    modport initiator (
        output req, add, wen, data, be, user, r_ready,
        input  gnt, r_data, r_valid, r_user
    );

    modport target (
        input  req, add, wen, data, be, user, r_ready,
        output gnt, r_data, r_valid, r_user
    );
endinterface

// File: rtl/hci_core_mem_responder.sv
// HCI-Core target endpoint backed by a single-port word memory.
// Reads return in order through S1 plus a (FIFO_DEPTH-1)-entry buffer.
// Optional feature: define HCI_CORE_MEM_RESPONDER_WRESP_EN to emit a
// zero-data response beat for every accepted write.
module hci_core_mem_responder #(
    parameter int unsigned NB_WORDS   = 1024,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DW         = 32,
    parameter int unsigned UW         = 1
) (
    input logic          clk_i,
    input logic          rst_ni,
    input logic          clear_i,
    hci_core_intf.target tcdm_target
);
    localparam int unsigned BW      = DW / 8;
    localparam int unsigned IdxW    = $clog2(NB_WORDS);
    localparam int unsigned FifoCap = FIFO_DEPTH - 1;
    localparam int unsigned FifoEnt = (FifoCap > 0) ? FifoCap : 1;
    localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
`ifdef HCI_CORE_MEM_RESPONDER_WRESP_EN
    localparam bit WrespEn = 1'b1;
`else
    localparam bit WrespEn = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
    } beat_t;

    logic [DW-1:0]   mem [NB_WORDS];
    logic [IdxW-1:0] idx;
    logic            accept;
    logic            push;
    logic            pop;
    logic            fifo_pop;
    logic            s1_retire;
    logic            s1_move;
    logic            s1_valid_q, s1_valid_d;
    beat_t           s1_q, s1_d;
    beat_t           fifo_q [FifoEnt];
    beat_t           fifo_d [FifoEnt];
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CntW-1:0] outstanding;
    logic            fifo_nonempty;
    beat_t           head;
    logic            unused_add;

    assign idx        = tcdm_target.add[IdxW+1:2];
    // Address bits above the word index and the byte offset are don't-care.
    assign unused_add = ^{tcdm_target.add[31:IdxW+2], tcdm_target.add[1:0]};

    assign fifo_nonempty = (fifo_cnt_q != '0);
    assign outstanding   = CntW'(s1_valid_q) + fifo_cnt_q;
    assign head          = fifo_nonempty ? fifo_q[0] : s1_q;

    assign tcdm_target.gnt     = !clear_i && (outstanding < CntW'(FIFO_DEPTH));
    assign tcdm_target.r_valid = fifo_nonempty || s1_valid_q;
    assign tcdm_target.r_data  = head.data;
    assign tcdm_target.r_user  = head.user;

    // Next state of the response path: retire head, advance S1, capture new beat.
    always_comb begin
        accept    = tcdm_target.req && tcdm_target.gnt;
        push      = accept && (tcdm_target.wen || WrespEn);
        pop       = tcdm_target.r_valid && tcdm_target.r_ready;
        fifo_pop  = pop && fifo_nonempty;
        s1_retire = pop && !fifo_nonempty;

        fifo_d = fifo_q;
        if (fifo_pop) begin
            for (int i = 0; i + 1 < FifoEnt; i++) begin
                fifo_d[i] = fifo_q[i+1];
            end
        end
        fifo_cnt_d = fifo_cnt_q - CntW'(fifo_pop);

        // S1 drains into the buffer whenever there is room behind the head.
        s1_move = s1_valid_q && !s1_retire && (fifo_cnt_d < CntW'(FifoCap));
        if (s1_move) begin
            for (int i = 0; i < FifoEnt; i++) begin
                if (CntW'(i) == fifo_cnt_d) begin
                    fifo_d[i] = s1_q;
                end
            end
            fifo_cnt_d = fifo_cnt_d + CntW'(1);
        end

        // gnt caps outstanding, so a push never lands on a stuck S1.
        s1_valid_d = push || (s1_valid_q && !s1_retire && !s1_move);
        s1_d       = s1_q;
        if (push) begin
            s1_d.data = tcdm_target.wen ? mem[idx] : '0;
            s1_d.user = tcdm_target.user;
        end

        if (clear_i) begin
            s1_valid_d = 1'b0;
            fifo_cnt_d = '0;
        end
    end

    // Response path registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < FifoEnt; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_q     <= fifo_d;
        end
    end

    // Byte-masked memory write; contents survive reset and clear.
    always_ff @(posedge clk_i) begin
        if (accept && !tcdm_target.wen) begin
            for (int b = 0; b < BW; b++) begin
                if (tcdm_target.be[b]) begin
                    mem[idx][8*b +: 8] <= tcdm_target.data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_hci_core_mem_responder.sv
// Bench for hci_core_mem_responder: directed vector table, hand-written
// reset/throughput sequences, then random traffic against a queue model.
module tb_hci_core_mem_responder;
    localparam int unsigned NB = 1024;
    localparam int unsigned FD = 2;
`ifdef HCI_CORE_MEM_RESPONDER_WRESP_EN
    localparam bit WR = 1'b1;
`else
    localparam bit WR = 1'b0;
`endif

    typedef struct {
        bit          req;
        bit          wen;
        int          word;
        logic [31:0] data;
        logic [3:0]  be;
        bit          user;
        bit          rr;
        bit          clr;
        bit          e_gnt;
        bit          e_rv;
        logic [31:0] e_rd;
        bit          e_ru;
        bit          cd;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        user;
    } beat_m_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    hci_core_intf #(.DW(32), .UW(1)) tcdm ();

    hci_core_mem_responder #(
        .NB_WORDS   (NB),
        .FIFO_DEPTH (FD),
        .DW         (32),
        .UW         (1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .tcdm_target (tcdm)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mem_m [NB];
    beat_m_t     q[$];
    bit          exp_gnt;
    vec_t        tbl [27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle's inputs and compare outputs with the model.
    task automatic drive(input bit req, input bit wen, input logic [31:0] add,
                         input logic [31:0] data, input logic [3:0] be, input bit user,
                         input bit rr, input bit clr);
        tcdm.req     = req;
        tcdm.wen     = wen;
        tcdm.add     = add;
        tcdm.data    = data;
        tcdm.be      = be;
        tcdm.user    = user;
        tcdm.r_ready = rr;
        clear        = clr;
        #1;
        exp_gnt = !clr && (q.size() < FD);
        chk("gnt", {31'b0, tcdm.gnt}, {31'b0, exp_gnt});
        chk("r_valid", {31'b0, tcdm.r_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("r_data", tcdm.r_data, q[0].data);
            chk("r_user", {31'b0, tcdm.r_user}, {31'b0, q[0].user});
        end
    endtask

    // Update the model as the clock edge would, then cross the edge.
    task automatic advance();
        int w;
        if (clear) begin
            q.delete();
        end else begin
            if (q.size() != 0 && tcdm.r_ready) void'(q.pop_front());
            if (tcdm.req && exp_gnt) begin
                w = int'((tcdm.add >> 2) % NB);
                if (tcdm.wen) begin
                    q.push_back(beat_m_t'{mem_m[w], tcdm.user});
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (tcdm.be[b]) mem_m[w][8*b +: 8] = tcdm.data[8*b +: 8];
                    if (WR) q.push_back(beat_m_t'{32'h0, tcdm.user});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t row(bit req, bit wen, int word, logic [31:0] data,
                                 logic [3:0] be, bit user, bit rr, bit clr, bit eg,
                                 bit erv, logic [31:0] erd, bit eru, bit cd);
        vec_t v;
        v = '{req, wen, word, data, be, user, rr, clr, eg, erv, erd, eru, cd};
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [31:0] a;
        //            req wen word      data          be    u  rr clr eg erv erd          eru cd
        tbl[0]  = row(0, 1, 0,        32'h0,        4'h0, 0, 1, 0, 1, 0,  32'h0,        0, 1);
        tbl[1]  = row(1, 0, 5,        32'hDEADBEEF, 4'hF, 0, 1, 0, 1, 0,  32'h0,        0, 1);
        tbl[2]  = row(1, 0, 5,        32'h000000AA, 4'h1, 0, 1, 0, 1, WR, 32'h0,        0, 1);
        tbl[3]  = row(1, 1, 5 + NB,   32'h0,        4'h0, 1, 1, 0, 1, WR, 32'h0,        0, 1);
        tbl[4]  = row(0, 1, 0,        32'h0,        4'h0, 0, 1, 0, 1, 1,  32'hDEADBEAA, 1, 1);
        tbl[5]  = row(0, 1, 0,        32'h0,        4'h0, 0, 1, 0, 1, 0,  32'h0,        0, 0);
        tbl[6]  = row(1, 0, 0,        32'h0,        4'hF, 0, 1, 0, 1, 0,  32'h0,        0, 0);
        tbl[7]  = row(1, 0, 1,        32'h1,        4'hF, 0, 1, 0, 1, WR, 32'h0,        0, WR);
        tbl[8]  = row(1, 0, 2,        32'h2,        4'hF, 0, 1, 0, 1, WR, 32'h0,        0, WR);
        tbl[9]  = row(1, 0, 3,        32'h3,        4'hF, 0, 1, 0, 1, WR, 32'h0,        0, WR);
        tbl[10] = row(0, 1, 0,        32'h0,        4'h0, 0, 1, 0, 1, WR, 32'h0,        0, WR);
        tbl[11] = row(1, 1, 0,        32'h0,        4'h0, 0, 0, 0, 1, 0,  32'h0,        0, 0);
        tbl[12] = row(1, 1, 1,        32'h0,        4'h0, 1, 0, 0, 1, 1,  32'h0,        0, 1);
        tbl[13] = row(1, 1, 2,        32'h0,        4'h0, 0, 0, 0, 0, 1,  32'h0,        0, 1);
        tbl[14] = row(1, 1, 2,        32'h0,        4'h0, 0, 0, 0, 0, 1,  32'h0,        0, 1);
        tbl[15] = row(1, 1, 2,        32'h0,        4'h0, 0, 1, 0, 0, 1,  32'h0,        0, 1);
        tbl[16] = row(1, 1, 2,        32'h0,        4'h0, 0, 1, 0, 1, 1,  32'h1,        1, 1);
        tbl[17] = row(1, 1, 3,        32'h0,        4'h0, 1, 1, 0, 1, 1,  32'h2,        0, 1);
        tbl[18] = row(0, 1, 0,        32'h0,        4'h0, 0, 1, 0, 1, 1,  32'h3,        1, 1);
        tbl[19] = row(0, 1, 0,        32'h0,        4'h0, 0, 1, 0, 1, 0,  32'h0,        0, 0);
        tbl[20] = row(1, 1, 0,        32'h0,        4'h0, 1, 0, 0, 1, 0,  32'h0,        0, 0);
        tbl[21] = row(1, 1, 1,        32'h0,        4'h0, 0, 0, 0, 1, 1,  32'h0,        1, 1);
        tbl[22] = row(1, 1, 2,        32'h0,        4'h0, 0, 0, 1, 0, 1,  32'h0,        1, 1);
        tbl[23] = row(0, 1, 0,        32'h0,        4'h0, 0, 0, 0, 1, 0,  32'h0,        0, 0);
        tbl[24] = row(1, 1, 1,        32'h0,        4'h0, 0, 1, 0, 1, 0,  32'h0,        0, 0);
        tbl[25] = row(0, 1, 0,        32'h0,        4'h0, 0, 1, 0, 1, 1,  32'h1,        0, 1);
        tbl[26] = row(0, 1, 0,        32'h0,        4'h0, 0, 1, 0, 1, 0,  32'h0,        0, 0);

        tcdm.req = 1'b0; tcdm.wen = 1'b1; tcdm.add = '0; tcdm.data = '0;
        tcdm.be = '0; tcdm.user = '0; tcdm.r_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            v = tbl[i];
            drive(v.req, v.wen, 32'(v.word) << 2, v.data, v.be, v.user, v.rr, v.clr);
            chk($sformatf("tbl%0d gnt", i), {31'b0, tcdm.gnt}, {31'b0, v.e_gnt});
            chk($sformatf("tbl%0d r_valid", i), {31'b0, tcdm.r_valid}, {31'b0, v.e_rv});
            if (v.cd) begin
                chk($sformatf("tbl%0d r_data", i), tcdm.r_data, v.e_rd);
                chk($sformatf("tbl%0d r_user", i), {31'b0, tcdm.r_user}, {31'b0, v.e_ru});
            end
            advance();
        end

        // Reset in the middle of a stall drops both pending beats.
        drive(1, 1, 32'h0, 32'h0, 4'h0, 1, 0, 0);
        advance();
        drive(1, 1, 32'h4, 32'h0, 4'h0, 0, 0, 0);
        advance();
        drive(0, 1, 32'h0, 32'h0, 4'h0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("rst r_valid", {31'b0, tcdm.r_valid}, 32'h0);
        chk("rst r_data", tcdm.r_data, 32'h0);
        chk("rst r_user", {31'b0, tcdm.r_user}, 32'h0);
        chk("rst gnt", {31'b0, tcdm.gnt}, 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1, 32'h0, 32'h0, 4'h0, 0, 1, 0);
        advance();
        drive(1, 1, 32'hC, 32'h0, 4'h0, 1, 1, 0);
        advance();
        drive(0, 1, 32'h0, 32'h0, 4'h0, 0, 1, 0);
        chk("post-rst mem word3", tcdm.r_data, 32'h3);
        advance();

        // Back-to-back reads at full rate with toggling user.
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 32'(i % 4) << 2, 32'h0, 4'h0, i[0], 1, 0);
            chk("stream gnt", {31'b0, tcdm.gnt}, 32'h1);
            advance();
        end
        drive(0, 1, 32'h0, 32'h0, 4'h0, 0, 1, 0);
        advance();

        // Random phase: seed 16 words, then mixed traffic with aliasing addresses.
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 32'(i) << 2, $urandom, 4'hF, 0, 1, 0);
            advance();
        end
        for (int i = 0; i < 600; i++) begin
            a = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 7)) << 12)
                | 32'($urandom_range(0, 3));
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a, $urandom,
                  4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
